// File: rtl/lane_pkg.sv
// Shared types, geometry constants and wrap helpers for the lane scheduler.
package lane_pkg;

   localparam int unsigned NUM_LANES    = 4;
   localparam int unsigned OBJS         = 4;
   localparam int unsigned TRACK_LEN    = 760;
   localparam int unsigned OBJ_W        = 80;
   localparam int unsigned LANE_Y_BASE  = 80;
   localparam int unsigned LANE_PITCH   = 40;
   localparam int unsigned LANE_STAGGER = 40;
   localparam int unsigned OBJ_SPACING  = TRACK_LEN / OBJS;
   localparam int unsigned POS_W        = 10;
   localparam int unsigned X_W          = 11;
   localparam int unsigned PERIOD_W     = 4;
   localparam int unsigned STEP_W       = 3;
   localparam int unsigned NOBJ_W       = 3;
   localparam int unsigned LEVEL_W      = 3;
   localparam int unsigned LANE_W       = 2;

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [X_W-1:0]   xcoord_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [PERIOD_W-1:0] period;
      logic [STEP_W-1:0]   step;
      logic                dir;
      logic [NOBJ_W-1:0]   nobj;
   } lane_cfg_t;

   // Staggered start layout so lanes do not line up vertically.
   function automatic pos_t init_pos(input int unsigned lane, input int unsigned obj);
      return POS_W'(lane * LANE_STAGGER + obj * OBJ_SPACING);
   endfunction

   // Shift into screen space; p < OBJ_W wraps to the top of the 11-bit range.
   function automatic xcoord_t to_x(input pos_t p);
      return X_W'({1'b0, p}) - X_W'(OBJ_W);
   endfunction

   function automatic logic [NOBJ_W-1:0] sat_nobj(input logic [NOBJ_W-1:0] n);
      return (n > NOBJ_W'(OBJS)) ? NOBJ_W'(OBJS) : n;
   endfunction

endpackage

// File: rtl/lane_scheduler_if.sv
// Control/config inputs and object position outputs of the lane scheduler.
interface lane_scheduler_if;
   import lane_pkg::*;

   logic                                        Frame_Clk;
   logic                                        Run;
   logic                                        Load;
   logic [LEVEL_W-1:0]                          Level;
   logic [NUM_LANES-1:0][PERIOD_W-1:0]          Lane_Period;
   logic [NUM_LANES-1:0][STEP_W-1:0]            Lane_Step;
   logic [NUM_LANES-1:0]                        Lane_Dir;
   logic [NUM_LANES-1:0][NOBJ_W-1:0]            Lane_Obj_Cfg;
   logic [NUM_LANES-1:0][OBJS-1:0][X_W-1:0]     Obj_X;
   logic [NUM_LANES-1:0][OBJS-1:0][X_W-1:0]     Obj_Y;
   logic [NUM_LANES-1:0][NOBJ_W-1:0]            Lane_Num_Obj;
   logic                                        Busy;
   logic                                        Update_Done;

   modport master (
      output Frame_Clk, Run, Load, Level, Lane_Period, Lane_Step, Lane_Dir, Lane_Obj_Cfg,
      input  Obj_X, Obj_Y, Lane_Num_Obj, Busy, Update_Done
   );

   modport slave (
      input  Frame_Clk, Run, Load, Level, Lane_Period, Lane_Step, Lane_Dir, Lane_Obj_Cfg,
      output Obj_X, Obj_Y, Lane_Num_Obj, Busy, Update_Done
   );

endinterface

// File: rtl/lane_step.sv
// Single-object move on the circular track: q = p +/- step, wrapped into 0..TRACK_LEN-1.
module lane_step
   import lane_pkg::*;
(
   input  pos_t              p,
   input  logic [STEP_W-1:0] step,
   input  logic              dir,
   output pos_t              q_c
);

   localparam int unsigned SUM_W = POS_W + 1;

   logic [SUM_W-1:0] sum;

   always_comb begin
      sum = SUM_W'({1'b0, p}) + SUM_W'(step);
      q_c = p;
      if (dir) begin
         if (sum >= SUM_W'(TRACK_LEN)) q_c = POS_W'(sum - SUM_W'(TRACK_LEN));
         else                          q_c = POS_W'(sum);
      end else begin
         if (p < POS_W'(step)) q_c = p + POS_W'(TRACK_LEN) - POS_W'(step);
         else                  q_c = p - POS_W'(step);
      end
   end

endmodule

// File: rtl/lane_scheduler.sv
// Per-frame lane sweep: one lane per cycle, speed-divided moves on a circular track.
// Optional build macro LANE_SPEEDUP_EN: effective period is reduced by Level (saturating at 0).
module lane_scheduler
   import lane_pkg::*;
(
   input logic             Clk,
   input logic             Reset_n,
   lane_scheduler_if.slave bus
);

   state_t              state, state_d;
   logic [LANE_W-1:0]   lane, lane_d;
   logic                pending, pending_d;
   logic                sample, prev;
   logic                tick, tick_go;
   logic                busy, update_done;
   lane_cfg_t           cfg        [NUM_LANES];
   logic [PERIOD_W-1:0] cnt        [NUM_LANES];
   logic [PERIOD_W-1:0] eff_period [NUM_LANES];
   pos_t                pos        [NUM_LANES][OBJS];
   pos_t                q_next     [OBJS];
   xcoord_t             obj_x      [NUM_LANES][OBJS];

   // Frame clock edge detect
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sample <= 1'b0;
         prev   <= 1'b0;
      end else begin
         sample <= bus.Frame_Clk;
         prev   <= sample;
      end
   end

   assign tick    = sample & ~prev;
   assign tick_go = tick & bus.Run;

`ifdef LANE_SPEEDUP_EN
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         eff_period[l] = '0;
         if (cfg[l].period > PERIOD_W'(bus.Level))
            eff_period[l] = cfg[l].period - PERIOD_W'(bus.Level);
      end
   end
`else
   logic unused_level;
   assign unused_level = ^bus.Level;

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) eff_period[l] = cfg[l].period;
   end
`endif

   for (genvar k = 0; k < OBJS; k++) begin : g_step
      lane_step u_step (
         .p    (pos[lane][k]),
         .step (cfg[lane].step),
         .dir  (cfg[lane].dir),
         .q_c  (q_next[k])
      );
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= S_IDLE;
         lane        <= '0;
         pending     <= 1'b0;
         busy        <= 1'b0;
         update_done <= 1'b0;
      end else begin
         state       <= state_d;
         lane        <= lane_d;
         pending     <= pending_d;
         busy        <= (state_d != S_IDLE);
         update_done <= (state_d == S_DONE);
      end
   end

   // Load overrides everything; a tick arriving mid-sweep is held one-deep
   always_comb begin
      state_d   = state;
      lane_d    = lane;
      pending_d = pending;
      if (bus.Load) begin
         state_d   = S_IDLE;
         lane_d    = '0;
         pending_d = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (tick_go) begin
                  state_d = S_SWEEP;
                  lane_d  = '0;
               end
            end
            S_SWEEP: begin
               if (tick_go) pending_d = 1'b1;
               if (lane == LANE_W'(NUM_LANES - 1)) state_d = S_DONE;
               else                                lane_d  = lane + LANE_W'(1);
            end
            S_DONE: begin
               if (pending || tick_go) begin
                  state_d   = S_SWEEP;
                  lane_d    = '0;
                  pending_d = 1'b0;
               end else begin
                  state_d   = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Positions, divider counters and latched config
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            cfg[l] <= '0;
            cnt[l] <= '0;
            for (int k = 0; k < OBJS; k++) begin
               pos[l][k]   <= init_pos(l, k);
               obj_x[l][k] <= to_x(init_pos(l, k));
            end
         end
      end else if (bus.Load) begin
         for (int l = 0; l < NUM_LANES; l++) begin
            cfg[l].period <= bus.Lane_Period[l];
            cfg[l].step   <= bus.Lane_Step[l];
            cfg[l].dir    <= bus.Lane_Dir[l];
            cfg[l].nobj   <= sat_nobj(bus.Lane_Obj_Cfg[l]);
            cnt[l]        <= '0;
            for (int k = 0; k < OBJS; k++) begin
               pos[l][k]   <= init_pos(l, k);
               obj_x[l][k] <= to_x(init_pos(l, k));
            end
         end
      end else if (state == S_SWEEP) begin
         if (cnt[lane] >= eff_period[lane]) begin
            cnt[lane] <= '0;
            for (int k = 0; k < OBJS; k++) begin
               pos[lane][k]   <= q_next[k];
               obj_x[lane][k] <= to_x(q_next[k]);
            end
         end else begin
            cnt[lane] <= cnt[lane] + PERIOD_W'(1);
         end
      end
   end

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         bus.Lane_Num_Obj[l] = cfg[l].nobj;
         for (int k = 0; k < OBJS; k++) begin
            bus.Obj_X[l][k] = obj_x[l][k];
            bus.Obj_Y[l][k] = X_W'(LANE_Y_BASE + l * LANE_PITCH);
         end
      end
   end

   assign bus.Busy        = busy;
   assign bus.Update_Done = update_done;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed bench for lane_scheduler: layout, sweep timing, wrap, divider, pending, load and reset.
module tb_lane_scheduler;
   import lane_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_fail;

   lane_scheduler_if bus ();

   lane_scheduler dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   pos_t              ls_p;
   logic [STEP_W-1:0] ls_step;
   logic              ls_dir;
   pos_t              ls_q;

   lane_step u_ls (
      .p    (ls_p),
      .step (ls_step),
      .dir  (ls_dir),
      .q_c  (ls_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_all(input logic [3:0] per, input logic [2:0] st, input logic d,
                          input logic [2:0] n);
      for (int l = 0; l < 4; l++) begin
         bus.Lane_Period[l]  = per;
         bus.Lane_Step[l]    = st;
         bus.Lane_Dir[l]     = d;
         bus.Lane_Obj_Cfg[l] = n;
      end
   endtask

   task automatic pulse_load();
      @(negedge clk);
      bus.Load = 1'b1;
      @(negedge clk);
      bus.Load = 1'b0;
   endtask

   // Returns at the negedge just before the edge where the tick is acted on
   task automatic frame_tick();
      @(negedge clk);
      bus.Frame_Clk = 1'b1;
      @(negedge clk);
      bus.Frame_Clk = 1'b0;
   endtask

   task automatic run_sweep();
      bit seen;
      bit ended;
      seen  = 0;
      ended = 0;
      frame_tick();
      for (int c = 0; c < 20 && !ended; c++) begin
         @(negedge clk);
         if (bus.Busy) seen = 1;
         else if (seen) ended = 1;
      end
      n_cmp++;
      if (!ended) begin
         n_fail++;
         $display("FAIL sweep_timeout: busy_seen=%0d ended=%0d required ended=1", seen, ended);
      end
   endtask

   task automatic test_reset();
      n_cmp++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d want 0", bus.Busy); end
      n_cmp++; if (bus.Update_Done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0d want 0", bus.Update_Done); end
      n_cmp++; if (bus.Lane_Num_Obj[1] !== 3'd0) begin n_fail++; $display("FAIL rst_nobj: got %0d want 0", bus.Lane_Num_Obj[1]); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL rst_x00: got %0d want 1968", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[3][3] !== 11'd610) begin n_fail++; $display("FAIL rst_x33: got %0d want 610", bus.Obj_X[3][3]); end
      n_cmp++; if (bus.Obj_Y[2][1] !== 11'd160) begin n_fail++; $display("FAIL rst_y21: got %0d want 160", bus.Obj_Y[2][1]); end
   endtask

   task automatic test_load();
      set_all(4'd0, 3'd4, 1'b1, 3'd3);
      bus.Lane_Obj_Cfg[2] = 3'd7;
      pulse_load();
      n_cmp++; if (bus.Lane_Num_Obj[0] !== 3'd3) begin n_fail++; $display("FAIL load_nobj0: got %0d want 3", bus.Lane_Num_Obj[0]); end
      n_cmp++; if (bus.Lane_Num_Obj[2] !== 3'd4) begin n_fail++; $display("FAIL load_nobj_sat: got %0d want 4", bus.Lane_Num_Obj[2]); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL load_x00: got %0d want 1968", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[1][1] !== 11'd150) begin n_fail++; $display("FAIL load_x11: got %0d want 150", bus.Obj_X[1][1]); end
      n_cmp++; if (bus.Obj_X[3][3] !== 11'd610) begin n_fail++; $display("FAIL load_x33: got %0d want 610", bus.Obj_X[3][3]); end
   endtask

   task automatic test_single_sweep();
      int dones;
      dones = 0;
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      pulse_load();
      frame_tick();
      @(negedge clk); // after E
      n_cmp++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy_e: got %0d want 1", bus.Busy); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL sw_x00_e: got %0d want 1968", bus.Obj_X[0][0]); end
      @(negedge clk); // after E+1
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1972) begin n_fail++; $display("FAIL sw_x00_e1: got %0d want 1972", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2008) begin n_fail++; $display("FAIL sw_x10_e1: got %0d want 2008", bus.Obj_X[1][0]); end
      @(negedge clk); // after E+2
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2012) begin n_fail++; $display("FAIL sw_x10_e2: got %0d want 2012", bus.Obj_X[1][0]); end
      @(negedge clk); // after E+3
      n_cmp++; if (bus.Obj_X[3][0] !== 11'd40) begin n_fail++; $display("FAIL sw_x30_e3: got %0d want 40", bus.Obj_X[3][0]); end
      n_cmp++; if (bus.Update_Done !== 1'b0) begin n_fail++; $display("FAIL sw_done_e3: got %0d want 0", bus.Update_Done); end
      @(negedge clk); // after E+4
      n_cmp++; if (bus.Obj_X[3][0] !== 11'd44) begin n_fail++; $display("FAIL sw_x30_e4: got %0d want 44", bus.Obj_X[3][0]); end
      n_cmp++; if (bus.Obj_X[3][3] !== 11'd614) begin n_fail++; $display("FAIL sw_x33_e4: got %0d want 614", bus.Obj_X[3][3]); end
      n_cmp++; if (bus.Update_Done !== 1'b1) begin n_fail++; $display("FAIL sw_done_e4: got %0d want 1", bus.Update_Done); end
      @(negedge clk); // after E+5
      n_cmp++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL sw_busy_e5: got %0d want 0", bus.Busy); end
      for (int c = 0; c < 6; c++) begin
         if (bus.Update_Done) dones++;
         @(negedge clk);
      end
      n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL sw_extra_done: got %0d want 0", dones); end
   endtask

   task automatic test_wrap_arith();
      logic [9:0] vp [7] = '{10'd758, 10'd1, 10'd759, 10'd0, 10'd3, 10'd100, 10'd755};
      logic [2:0] vs [7] = '{3'd4, 3'd3, 3'd1, 3'd0, 3'd3, 3'd7, 3'd4};
      logic       vd [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] vq [7] = '{10'd2, 10'd758, 10'd0, 10'd0, 10'd0, 10'd107, 10'd759};
      for (int i = 0; i < 7; i++) begin
         ls_p = vp[i]; ls_step = vs[i]; ls_dir = vd[i];
         #1;
         n_cmp++;
         if (ls_q !== vq[i]) begin
            n_fail++;
            $display("FAIL wrap_arith[%0d]: p=%0d step=%0d dir=%0d got %0d want %0d",
                     i, vp[i], vs[i], vd[i], ls_q, vq[i]);
         end
      end
   endtask

   task automatic test_left_wrap();
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      bus.Lane_Dir[0]  = 1'b0;
      bus.Lane_Step[0] = 3'd3;
      pulse_load();
      run_sweep();
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd677) begin n_fail++; $display("FAIL lwrap_x00: got %0d want 677", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[0][1] !== 11'd107) begin n_fail++; $display("FAIL lwrap_x01: got %0d want 107", bus.Obj_X[0][1]); end
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2012) begin n_fail++; $display("FAIL lwrap_x10: got %0d want 2012", bus.Obj_X[1][0]); end
   endtask

   task automatic test_right_wrap();
      set_all(4'd0, 3'd6, 1'b1, 3'd4);
      pulse_load();
      for (int t = 0; t < 12; t++) run_sweep();
      n_cmp++; if (bus.Obj_X[3][3] !== 11'd1970) begin n_fail++; $display("FAIL rwrap_x33: got %0d want 1970", bus.Obj_X[3][3]); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd2040) begin n_fail++; $display("FAIL rwrap_x00: got %0d want 2040", bus.Obj_X[0][0]); end
   endtask

   task automatic test_period();
      logic [10:0] exp_x;
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      bus.Lane_Period[0] = 4'd2;
      bus.Level = 3'd2;
      pulse_load();
      for (int t = 1; t <= 9; t++) begin
         run_sweep();
`ifdef LANE_SPEEDUP_EN
         exp_x = 11'(1968 + 4 * t);
`else
         exp_x = 11'(1968 + 4 * (t / 3));
`endif
         n_cmp++;
         if (bus.Obj_X[0][0] !== exp_x) begin
            n_fail++;
            $display("FAIL period_tick%0d: got %0d want %0d", t, bus.Obj_X[0][0], exp_x);
         end
      end
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2044) begin n_fail++; $display("FAIL period_lane1: got %0d want 2044", bus.Obj_X[1][0]); end
      bus.Level = 3'd0;
   endtask

   task automatic test_run_pause();
      bit busy_seen;
      busy_seen = 0;
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      pulse_load();
      bus.Run = 1'b0;
      frame_tick();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.Busy) busy_seen = 1;
      end
      bus.Run = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.Busy) busy_seen = 1;
      end
      n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %0d want 0", busy_seen); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL pause_x00: got %0d want 1968", bus.Obj_X[0][0]); end
   endtask

   task automatic test_back_to_back();
      int dones;
      bit busy_gap;
      dones    = 0;
      busy_gap = 0;
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      pulse_load();
      @(negedge clk);
      bus.Frame_Clk = 1'b1;
      // Iteration i samples after edge E-1+i; ticks are acted on at E, E+2 and E+4
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.Update_Done) dones++;
         if (i >= 1 && i <= 10 && !bus.Busy) busy_gap = 1;
         if (i == 11) begin
            n_cmp++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0d want 0", bus.Busy); end
         end
         bus.Frame_Clk = (i == 1 || i == 3);
      end
      n_cmp++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d want 2", dones); end
      n_cmp++; if (busy_gap !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d want 0", busy_gap); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1976) begin n_fail++; $display("FAIL b2b_x00: got %0d want 1976", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[3][1] !== 11'd238) begin n_fail++; $display("FAIL b2b_x31: got %0d want 238", bus.Obj_X[3][1]); end
   endtask

   task automatic test_load_abort();
      int dones;
      bit busy_seen;
      dones     = 0;
      busy_seen = 0;
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      pulse_load();
      frame_tick();
      repeat (3) @(negedge clk); // after E+2
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2012) begin n_fail++; $display("FAIL abort_x10_mid: got %0d want 2012", bus.Obj_X[1][0]); end
      n_cmp++; if (bus.Obj_X[2][0] !== 11'd0) begin n_fail++; $display("FAIL abort_x20_mid: got %0d want 0", bus.Obj_X[2][0]); end
      bus.Load = 1'b1;
      @(negedge clk);
      bus.Load = 1'b0;
      n_cmp++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d want 0", bus.Busy); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL abort_x00: got %0d want 1968", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2008) begin n_fail++; $display("FAIL abort_x10: got %0d want 2008", bus.Obj_X[1][0]); end
      for (int c = 0; c < 6; c++) begin
         if (bus.Update_Done) dones++;
         @(negedge clk);
      end
      n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", dones); end
      // Load coinciding with a tick swallows the tick
      @(negedge clk);
      bus.Frame_Clk = 1'b1;
      @(negedge clk);
      bus.Frame_Clk = 1'b0;
      bus.Load      = 1'b1;
      @(negedge clk);
      bus.Load = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (bus.Busy) busy_seen = 1;
         @(negedge clk);
      end
      n_cmp++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL load_tick_busy: got %0d want 0", busy_seen); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL load_tick_x00: got %0d want 1968", bus.Obj_X[0][0]); end
   endtask

   task automatic test_reset_mid();
      set_all(4'd0, 3'd4, 1'b1, 3'd4);
      pulse_load();
      frame_tick();
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %0d want 0", bus.Busy); end
      n_cmp++; if (bus.Obj_X[0][0] !== 11'd1968) begin n_fail++; $display("FAIL mrst_x00: got %0d want 1968", bus.Obj_X[0][0]); end
      n_cmp++; if (bus.Obj_X[1][0] !== 11'd2008) begin n_fail++; $display("FAIL mrst_x10: got %0d want 2008", bus.Obj_X[1][0]); end
      n_cmp++; if (bus.Lane_Num_Obj[0] !== 3'd0) begin n_fail++; $display("FAIL mrst_nobj: got %0d want 0", bus.Lane_Num_Obj[0]); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++; if (bus.Update_Done !== 1'b0) begin n_fail++; $display("FAIL mrst_done: got %0d want 0", bus.Update_Done); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.Frame_Clk = 1'b0;
      bus.Run       = 1'b1;
      bus.Load      = 1'b0;
      bus.Level     = 3'd0;
      ls_p = '0; ls_step = '0; ls_dir = 1'b0;
      set_all(4'd0, 3'd0, 1'b0, 3'd0);
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_load();
      test_single_sweep();
      test_wrap_arith();
      test_left_wrap();
      test_right_wrap();
      test_period();
      test_run_pause();
      test_back_to_back();
      test_load_abort();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lane_scheduler.md
# lane_scheduler

Per-frame motion sequencer for the four traffic/river lanes feeding the colour mapper. On each rising edge of the frame clock it sweeps the lanes one per cycle and advances every object's horizontal position by a per-lane step and direction, gated by a per-lane speed divider. Positions wrap on a 760-pixel circular track, and it emits the 11-bit signed-wrap X format the colour mapper consumes. It sits between game control (level load, run/pause) and the colour mapper / collision logic.

## Interface
- NUM_LANES, 4, lanes handled.
- OBJS, 4, objects per lane.
- TRACK_LEN, 760, circular track length in pixels (640 visible + 2×OBJ_W margin minus overlap).
- OBJ_W, 80, object width; X = p − OBJ_W.
- LANE_Y_BASE, 80, Y of lane 0; LANE_PITCH, 40, Y spacing between lanes.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- Frame_Clk  in  1  vsync-derived level; rising edge = frame tick.
- Run  in  1  1 = accept ticks; 0 = paused.
- Load  in  1  single-cycle pulse: latch config, reinitialise layout.
- Level  in  3  current level (used only under LANE_SPEEDUP_EN).
- Lane_Period  in  [3:0][3:0]  frames-minus-one between moves, per lane.
- Lane_Step  in  [3:0][2:0]  pixels per move, per lane.
- Lane_Dir  in  [3:0]  1 = rightward, 0 = leftward.
- Lane_Obj_Cfg  in  [3:0][2:0]  object count per lane, saturated to 4.
- Obj_X  out  [3:0][3:0][10:0]  object X per [lane][obj].
- Obj_Y  out  [3:0][3:0][10:0]  LANE_Y_BASE + lane×LANE_PITCH, constant.
- Lane_Num_Obj  out  [3:0][2:0]  active objects per lane.
- Busy  out  1  sweep in progress.
- Update_Done  out  1  one-cycle pulse when sweep completes.

## Operation
- Internal position p[L][k], 10 bits, range 0..759. Obj_X = {1'b0,p} − 80, mod 2^11; p<80 yields 1968..2047 (partially off-left).
- Initial layout: p = L×40 + k×190; all values < 760.
- Tick: Frame_Clk sampled into a register; tick = sample & ~prev.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: on tick with Run=1 → SWEEP, lane=0.
  - SWEEP: process lane `lane`; at lane 3 → DONE.
  - DONE: Update_Done=1 → IDLE.
- Lane processing, all OBJS in parallel:
  - If cnt[L] ≥ eff_period[L], move and set cnt=0; else cnt++.
  - Right: q = p+step; if q ≥ 760 then q −= 760.
  - Left: if p < step then q = p + 760 − step else q = p − step.
- Pending: a tick during SWEEP/DONE sets a one-deep pending flag. From DONE, pending → SWEEP directly, clearing the flag. Additional ticks while pending is set are dropped.
- Run=0: ticks are ignored and not made pending. A sweep already in progress completes.
- Load (any state): latch Period/Step/Dir/Obj_Cfg, restore initial layout, clear all cnt and pending → IDLE. No Update_Done is issued. Load has priority over a simultaneous tick, and that tick is lost.
- Objects with k ≥ Lane_Num_Obj still move; the consumer masks them.
- Reset values: state IDLE, p = initial layout, cnt=0, latched config 0 (period 0, step 0, dir 0), Lane_Num_Obj=0, Busy=0, Update_Done=0, pending=0, prev=0.

## Timing
- Tick detected at edge E. Lane L updates at edge E+1+L. Update_Done is high for the cycle after edge E+4. IDLE is reached at E+5, or SWEEP if pending.
- Busy = (state != IDLE), registered with the state.
- Obj_X/Obj_Y/Lane_Num_Obj are registered. Config takes effect from the cycle after Load.

## Configuration
- LANE_SPEEDUP_EN defined: eff_period = Lane_Period − Level, saturated at 0.
- Undefined: eff_period = Lane_Period, and Level is unused.

## Structure
- Package lane_pkg holds NUM_LANES, OBJS, TRACK_LEN, OBJ_W, the state enum, and the typedefs pos_t (10-bit), xcoord_t (11-bit), lane_cfg_t {period, step, dir, nobj}.
- Sub-module lane_step: combinational single-object wrap arithmetic (p, step, dir → q), instantiated OBJS times.

## Test plan
- Reset, then Load with Obj_Cfg=3 for all lanes → Obj_X[0][0]=2048−80=1968, Obj_X[1][1]=150, Obj_X[3][3]=610; Lane_Num_Obj=3.
- Period=0, Step=4, Dir=1, one tick → lane0 obj0 X 1968→1972 at E+1; lane3 changes at E+4; Update_Done high exactly one cycle.
- Right wrap: p=758, step=4 → p=2, X=1970. Left wrap: p=1, step=3 → p=758, X=678.
- Period=2 → movement on ticks 3, 6, 9 only. With LANE_SPEEDUP_EN and Level=2 → moves every tick.
- Second tick at E+2 → pending; second sweep starts right after DONE (Busy continuous, 2 Done pulses). A third tick at E+3 is dropped.
- Load asserted at E+2 → lanes 0–1 moved, layout restored next cycle, no Update_Done, Busy=0. Reset_n low mid-sweep → all outputs at reset values immediately.
